mux_2to1: RTL and testbench
===========================

// Module: mux_2to1
// PURPOSE
//  - Parameterised 2:1 word multiplexer for the single-cycle MIPS datapath (ALUSrc, MemtoReg, PCSrc style selects).
//  - Combinational path outputData = select ? inputB : inputA, usable within the same cycle.
//  - Adds a registered copy with a valid flag and a saturating select-toggle counter for datapath debug.
// PARAMETERS
//  DATA_WIDTH  32  width of inputA, inputB, outputData, outputData_q (>=1)
//  CNT_WIDTH   16  width of sel_toggle_cnt (>=1)
// PORTS
//  clk             in   1            rising-edge clock
//  rst_n           in   1            reset, asynchronous, active-low
//  inputA          in   DATA_WIDTH   data input selected when select=0
//  inputB          in   DATA_WIDTH   data input selected when select=1
//  select          in   1            0 -> inputA, 1 -> inputB
//  in_valid        in   1            qualifies inputs for the registered stage
//  outputData      out  DATA_WIDTH   combinational mux result
//  outputData_q    out  DATA_WIDTH   registered mux result
//  out_valid       out  1            outputData_q holds a captured word
//  sel_toggle_cnt  out  CNT_WIDTH    number of select changes seen while in_valid=1, saturating
// BEHAVIOUR
//  - The clock is single and reset is asynchronous, active-low: clk, rst_n.
//  - outputData is purely combinational, zero latency.
//  - outputData ignores clk, rst_n and in_valid.
//  - X/Z on select: outputData = all-X in simulation. Synthesis treats it as don't-care.
//  - Asynchronous assertion of rst_n=0 sets:
//      - outputData_q = 0, out_valid = 0, sel_toggle_cnt = 0, sel_prev = 0.
//  - Reset asserted mid-operation clears these immediately. Release is synchronous to the next clk edge.
//  - Posedge clk with in_valid=1:
//      - outputData_q <= mux result, out_valid <= 1 (latency 1 cycle).
//  - Posedge clk with in_valid=0:
//      - outputData_q holds, out_valid <= 0.
//  - Toggle counter:
//      - sel_prev updates only on in_valid=1 cycles.
//      - When in_valid=1 and select != sel_prev, sel_toggle_cnt increments by 1.
//      - The counter saturates at all-ones with no wrap.
//      - The first valid select after reset is compared against sel_prev=0.
//  - Widths are fixed: no sign extension or truncation; outputs match DATA_WIDTH exactly.
// CONFIGURATION
//  - Macro MUX2TO1_PARITY_EN:
//      - Defined: extra output out_parity (1 bit) = even parity (XOR-reduce) of outputData_q. It is registered alongside outputData_q and reset to 0.
//      - Undefined: the out_parity port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package mux2to1_pkg:
//      - localparam DEFAULT_DATA_WIDTH=32, DEFAULT_CNT_WIDTH=16.
//      - typedef enum logic {SEL_A=1'b0, SEL_B=1'b1} sel_e.
//  - Sub-module mux2to1_sel_core: purely combinational selector (DATA_WIDTH). It drives outputData and feeds the register stage.
//  - Top: register stage, toggle counter, optional parity.
// TESTING
//  1. A=32'hAABBCCDD, B=32'h00112233, select=0, wait 10ns -> outputData=32'hAABBCCDD.
//  2. Same A/B, select=1, wait 10ns -> outputData=32'h00112233 without any clk edge.
//  3. in_valid=1, select=1, one posedge -> outputData_q=32'h00112233, out_valid=1. Then in_valid=0, one posedge -> out_valid=0, outputData_q holds.
//  4. in_valid=1, select alternating 0,1,0,1 over 4 edges -> sel_toggle_cnt=3. With CNT_WIDTH=2, forced past 3 -> stays 2'b11.
//  5. rst_n=0 asynchronously between edges -> outputData_q=0, out_valid=0, sel_toggle_cnt=0 at once; outputData still tracks inputs.
//  6. With MUX2TO1_PARITY_EN, capture 32'h00000007 -> out_parity=1; capture 32'h00000003 -> out_parity=0.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// Shared definitions for the 2:1 datapath multiplexer.
//   DEFAULT_DATA_WIDTH : default word width for data inputs and outputs
//   DEFAULT_CNT_WIDTH  : default width of the select-toggle debug counter
//   sel_e              : select encoding (SEL_A picks inputA, SEL_B picks inputB)
package mux2to1_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage

// File: rtl/mux2to1_sel_core.sv
// Purely combinational 2:1 word selector.
// Ports:
//   inputA     in  DATA_WIDTH  word chosen when select=0
//   inputB     in  DATA_WIDTH  word chosen when select=1
//   select     in  1           word select
//   outputData out DATA_WIDTH  selected word, zero latency
module mux2to1_sel_core
    import mux2to1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] inputA,
    input  logic [DATA_WIDTH-1:0] inputB,
    input  logic                  select,
    output logic [DATA_WIDTH-1:0] outputData
);

    // An unknown select falls through to the default branch, so simulation
    // shows an all-X word instead of a bitwise merge of the two inputs;
    // synthesis is free to treat that branch as don't-care.
    always_comb begin
        outputData = 'x;
        case (select)
            SEL_A:   outputData = inputA;
            SEL_B:   outputData = inputB;
            default: outputData = 'x;
        endcase
    end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 word multiplexer for the single-cycle datapath, with a registered
// debug copy, a valid flag and a saturating select-toggle counter.
// Optional feature macro: MUX2TO1_PARITY_EN adds the out_parity output.
// Ports:
//   clk            in  1           rising-edge clock
//   rst_n          in  1           asynchronous active-low reset
//   inputA         in  DATA_WIDTH  word selected when select=0
//   inputB         in  DATA_WIDTH  word selected when select=1
//   select         in  1           0 -> inputA, 1 -> inputB
//   in_valid       in  1           qualifies inputs for the registered stage
//   outputData     out DATA_WIDTH  combinational mux result
//   outputData_q   out DATA_WIDTH  registered mux result
//   out_valid      out 1           outputData_q holds a freshly captured word
//   sel_toggle_cnt out CNT_WIDTH   saturating count of select changes on valid cycles
//   out_parity     out 1           (MUX2TO1_PARITY_EN only) XOR of outputData_q
module mux_2to1
    import mux2to1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] inputA,
    input  logic [DATA_WIDTH-1:0] inputB,
    input  logic                  select,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] outputData,
    output logic [DATA_WIDTH-1:0] outputData_q,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  sel_toggle_cnt
`ifdef MUX2TO1_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    sel_e selPrev;

    mux2to1_sel_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) selCore (
        .inputA     (inputA),
        .inputB     (inputB),
        .select     (select),
        .outputData (outputData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outputData_q <= '0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                outputData_q <= outputData;
            end
        end
    end

    // selPrev starts at SEL_A so the first valid select=1 after reset counts
    // as a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selPrev        <= SEL_A;
            sel_toggle_cnt <= '0;
        end else if (in_valid) begin
            selPrev <= sel_e'(select);
            if ((sel_e'(select) != selPrev) && (sel_toggle_cnt != CNT_MAX)) begin
                sel_toggle_cnt <= sel_toggle_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef MUX2TO1_PARITY_EN
    // Captured together with outputData_q so it always describes that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (in_valid) begin
            out_parity <= ^outputData;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
module tb_mux_2to1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inputA = '0;
    logic [31:0] inputB = '0;
    logic        select = 1'b0;
    logic        in_valid = 1'b0;

    logic [31:0] outputData, outputData_q;
    logic        out_valid;
    logic [15:0] sel_toggle_cnt;

    logic [7:0]  sOutputData, sOutputData_q;
    logic        sOutValid;
    logic [1:0]  sSelToggleCnt;

`ifdef MUX2TO1_PARITY_EN
    logic        out_parity, sOutParity;
`endif

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    mux_2to1 #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inputA         (inputA),
        .inputB         (inputB),
        .select         (select),
        .in_valid       (in_valid),
        .outputData     (outputData),
        .outputData_q   (outputData_q),
        .out_valid      (out_valid),
        .sel_toggle_cnt (sel_toggle_cnt)
`ifdef MUX2TO1_PARITY_EN
        ,
        .out_parity     (out_parity)
`endif
    );

    mux_2to1 #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dutSmall (
        .clk            (clk),
        .rst_n          (rst_n),
        .inputA         (inputA[7:0]),
        .inputB         (inputB[7:0]),
        .select         (select),
        .in_valid       (in_valid),
        .outputData     (sOutputData),
        .outputData_q   (sOutputData_q),
        .out_valid      (sOutValid),
        .sel_toggle_cnt (sSelToggleCnt)
`ifdef MUX2TO1_PARITY_EN
        ,
        .out_parity     (sOutParity)
`endif
    );

    // Reference model: last captured word, valid flag, the select seen on the
    // last valid cycle and the raw (unbounded) number of select changes.
    logic [31:0] mQ;
    logic        mValid;
    logic        mPrevSel;
    int          mToggles;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQ       <= '0;
            mValid   <= 1'b0;
            mPrevSel <= 1'b0;
            mToggles <= 0;
        end else begin
            mValid <= in_valid;
            if (in_valid) begin
                mQ       <= select ? inputB : inputA;
                mPrevSel <= select;
                if (select != mPrevSel) mToggles <= mToggles + 1;
            end
        end
    end

    function automatic int satTo(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("comb32", 64'(outputData), 64'(select ? inputB : inputA));
            check("comb8", 64'(sOutputData), 64'(select ? inputB[7:0] : inputA[7:0]));
            check("q32", 64'(outputData_q), 64'(mQ));
            check("q8", 64'(sOutputData_q), 64'(mQ[7:0]));
            check("valid32", 64'(out_valid), 64'(mValid));
            check("valid8", 64'(sOutValid), 64'(mValid));
            check("cnt16", 64'(sel_toggle_cnt), 64'(satTo(mToggles, 65535)));
            check("cnt2", 64'(sSelToggleCnt), 64'(satTo(mToggles, 3)));
`ifdef MUX2TO1_PARITY_EN
            check("par32", 64'(out_parity), 64'(^mQ));
            check("par8", 64'(sOutParity), 64'(^mQ[7:0]));
`endif
        end
    end

    task automatic nextDrive();
        @(posedge clk);
        #2;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_q", 64'(outputData_q), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_cnt", 64'(sel_toggle_cnt), 64'h0);

        nextDrive();
        rst_n  = 1'b1;
        checkEn = 1'b1;

        // Combinational path, no clock edge between drive and check.
        inputA = 32'hAABBCCDD;
        inputB = 32'h00112233;
        select = 1'b0;
        #1 check("t1_comb", 64'(outputData), 64'hAABBCCDD);
        select = 1'b1;
        #1 check("t2_comb", 64'(outputData), 64'h00112233);

        // Capture then idle.
        in_valid = 1'b1;
        afterEdge();
        check("t3_q", 64'(outputData_q), 64'h00112233);
        check("t3_valid", 64'(out_valid), 64'h1);
        #1 in_valid = 1'b0;
        afterEdge();
        check("t3_valid_drop", 64'(out_valid), 64'h0);
        check("t3_q_hold", 64'(outputData_q), 64'h00112233);

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        select = 1'b0;
        inputA = 32'h12345678;
        #1;
        check("t5_q", 64'(outputData_q), 64'h0);
        check("t5_valid", 64'(out_valid), 64'h0);
        check("t5_cnt", 64'(sel_toggle_cnt), 64'h0);
        check("t5_comb", 64'(outputData), 64'h12345678);
        nextDrive();
        rst_n = 1'b1;

        // Alternating select 0,1,0,1 gives three toggles; then push the
        // 2-bit counter past its limit.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            select = i[0];
            afterEdge();
            #1;
        end
        check("t4_cnt16", 64'(sel_toggle_cnt), 64'd3);
        check("t4_cnt2", 64'(sSelToggleCnt), 64'd3);
        for (int i = 0; i < 2; i++) begin
            select = ~select;
            afterEdge();
            #1;
        end
        check("t4_cnt16_more", 64'(sel_toggle_cnt), 64'd5);
        check("t4_cnt2_sat", 64'(sSelToggleCnt), 64'd3);

`ifdef MUX2TO1_PARITY_EN
        select = 1'b0;
        inputA = 32'h00000007;
        afterEdge();
        check("t6_par7", 64'(out_parity), 64'h1);
        #1 inputA = 32'h00000003;
        afterEdge();
        check("t6_par3", 64'(out_parity), 64'h0);
        #1;
`endif

        // Randomised traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            nextDrive();
            rst_n    = 1'b1;
            inputA   = $urandom;
            inputB   = $urandom;
            select   = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
            end
        end
        nextDrive();
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkEn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
